ghost_mover: RTL and testbench

Consumes the 3-bit ghost direction code from the switch-input stage and moves the ghost one maze cell per movement tick. Each step queries the maze wall ROM for the target cell and commits the move only when the cell is open and inside the grid. Outputs are the ghost cell coordinates for the VGA renderer and the collision logic.

---
 rtl/ghost_mover.sv | 191 +++++++++++++++++++
 tb/tb_ghost_mover.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mover.sv
// Ghost mover: steps the ghost one maze cell per movement tick, gated by the maze wall ROM.
// Latency: tick in cycle T -> new position and step_done/blocked pulse visible in cycle T+3.
// Backpressure: none; ticks are spaced >= 4 cycles so a move always finishes before the next tick.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   ghost_dir             - 0 stay, 1 right, 2 left, 3 up, 4 down (5-7 = stay), sampled on tick only
//   wall_qx/wall_qy       - registered wall ROM query address
//   wall_hit              - ROM data (1 = wall), valid one cycle after the query address
//   ghost_x/ghost_y       - current ghost cell
//   step_done/blocked     - one-cycle pulses: move committed / move rejected
// Optional: define TUNNEL_WRAP_EN to make the left/right grid edges a wrap-around tunnel.
module ghost_mover #(
    parameter int GRID_W   = 20,
    parameter int GRID_H   = 15,
    parameter int X_W      = 5,
    parameter int Y_W      = 4,
    parameter int START_X  = 9,
    parameter int START_Y  = 7,
    parameter int STEP_DIV = 2500000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     ghost_dir,
    output logic [X_W-1:0] wall_qx,
    output logic [Y_W-1:0] wall_qy,
    input  logic           wall_hit,
    output logic [X_W-1:0] ghost_x,
    output logic [Y_W-1:0] ghost_y,
    output logic           step_done,
    output logic           blocked
);

    localparam int CNT_W = $clog2(STEP_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    // Candidate target derived from the current cell and direction
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic           cand_oob;
    logic           cand_move;

    // Latched target for the move in flight
    logic [X_W-1:0] tgt_x, tgt_x_nxt;
    logic [Y_W-1:0] tgt_y, tgt_y_nxt;
    logic           tgt_oob, tgt_oob_nxt;

    logic [X_W-1:0] wall_qx_nxt, ghost_x_nxt;
    logic [Y_W-1:0] wall_qy_nxt, ghost_y_nxt;
    logic           step_done_nxt, blocked_nxt;

    // Free-running movement tick divider, independent of FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign tick = (tick_cnt == CNT_W'(STEP_DIV - 1));

    // Edge checks come before the +/-1 so coordinates never wrap silently.
    // An out-of-bounds candidate keeps the current cell as its address.
    always_comb begin
        cand_x    = ghost_x;
        cand_y    = ghost_y;
        cand_oob  = 1'b0;
        cand_move = 1'b1;
        case (ghost_dir)
            3'd1: begin
                if (ghost_x == X_W'(GRID_W - 1)) begin
`ifdef TUNNEL_WRAP_EN
                    cand_x = '0;
`else
                    cand_oob = 1'b1;
`endif
                end else begin
                    cand_x = ghost_x + X_W'(1);
                end
            end
            3'd2: begin
                if (ghost_x == '0) begin
`ifdef TUNNEL_WRAP_EN
                    cand_x = X_W'(GRID_W - 1);
`else
                    cand_oob = 1'b1;
`endif
                end else begin
                    cand_x = ghost_x - X_W'(1);
                end
            end
            3'd3: begin
                if (ghost_y == '0) begin
                    cand_oob = 1'b1;
                end else begin
                    cand_y = ghost_y - Y_W'(1);
                end
            end
            3'd4: begin
                if (ghost_y == Y_W'(GRID_H - 1)) begin
                    cand_oob = 1'b1;
                end else begin
                    cand_y = ghost_y + Y_W'(1);
                end
            end
            default: cand_move = 1'b0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt     = state;
        tgt_x_nxt     = tgt_x;
        tgt_y_nxt     = tgt_y;
        tgt_oob_nxt   = tgt_oob;
        wall_qx_nxt   = wall_qx;
        wall_qy_nxt   = wall_qy;
        ghost_x_nxt   = ghost_x;
        ghost_y_nxt   = ghost_y;
        step_done_nxt = 1'b0;
        blocked_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (tick && cand_move) begin
                    tgt_x_nxt   = cand_x;
                    tgt_y_nxt   = cand_y;
                    tgt_oob_nxt = cand_oob;
                    wall_qx_nxt = cand_oob ? ghost_x : cand_x;
                    wall_qy_nxt = cand_oob ? ghost_y : cand_y;
                    state_nxt   = QUERY;
                end
            end
            QUERY: begin
                // ROM registers the address during this cycle
                state_nxt = CHECK;
            end
            CHECK: begin
                // Out-of-bounds moves still take this path for fixed latency; wall_hit is ignored
                if (!tgt_oob && !wall_hit) begin
                    ghost_x_nxt   = tgt_x;
                    ghost_y_nxt   = tgt_y;
                    step_done_nxt = 1'b1;
                end else begin
                    blocked_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tgt_x     <= X_W'(START_X);
            tgt_y     <= Y_W'(START_Y);
            tgt_oob   <= 1'b0;
            wall_qx   <= X_W'(START_X);
            wall_qy   <= Y_W'(START_Y);
            ghost_x   <= X_W'(START_X);
            ghost_y   <= Y_W'(START_Y);
            step_done <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt_x     <= tgt_x_nxt;
            tgt_y     <= tgt_y_nxt;
            tgt_oob   <= tgt_oob_nxt;
            wall_qx   <= wall_qx_nxt;
            wall_qy   <= wall_qy_nxt;
            ghost_x   <= ghost_x_nxt;
            ghost_y   <= ghost_y_nxt;
            step_done <= step_done_nxt;
            blocked   <= blocked_nxt;
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
module tb_ghost_mover;

    localparam int GRID_W   = 20;
    localparam int GRID_H   = 15;
    localparam int X_W      = 5;
    localparam int Y_W      = 4;
    localparam int START_X  = 9;
    localparam int START_Y  = 7;
    localparam int STEP_DIV = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [2:0]     ghost_dir = 3'd0;
    logic [X_W-1:0] wall_qx;
    logic [Y_W-1:0] wall_qy;
    logic           wall_hit = 1'b0;
    logic [X_W-1:0] ghost_x;
    logic [Y_W-1:0] ghost_y;
    logic           step_done;
    logic           blocked;

    ghost_mover #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
        .START_X(START_X), .START_Y(START_Y), .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk), .reset(reset), .ghost_dir(ghost_dir),
        .wall_qx(wall_qx), .wall_qy(wall_qy), .wall_hit(wall_hit),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .step_done(step_done), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Wall ROM model: a single optional wall cell, one-cycle read latency
    bit wall_en = 1'b0;
    int wall_cx = 0;
    int wall_cy = 0;

    function automatic bit is_wall(input int x, input int y);
        return wall_en && (x == wall_cx) && (y == wall_cy);
    endfunction

    always @(posedge clk) wall_hit <= is_wall(int'(wall_qx), int'(wall_qy));

    // Reference tick counter
    int cnt = 0;
    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else if (cnt == STEP_DIV - 1) cnt <= 0;
        else cnt <= cnt + 1;
    end

    // Reference ghost position and query address
    int ex = START_X, ey = START_Y;
    int mqx = START_X, mqy = START_Y;

    typedef struct {
        int x;
        int y;
        bit step;
        bit blk;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_step"}, 32'(step_done), 0);
        chk({tag, "_blk"}, 32'(blocked), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gx", 32'(ghost_x), START_X);
        chk("rst_gy", 32'(ghost_y), START_Y);
        chk("rst_qx", 32'(wall_qx), START_X);
        chk("rst_qy", 32'(wall_qy), START_Y);
        chk_quiet("rst");
        reset = 1'b0;
        ex = START_X; ey = START_Y; mqx = START_X; mqy = START_Y;
        sb.delete();
    endtask

    task automatic wait_tick();
        int n = 0;
        while (cnt != STEP_DIV - 1 && n < 3 * STEP_DIV) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3 * STEP_DIV) chk("tick_timeout", 1, 0);
    endtask

    // Expected outcome of a tick with direction dir, pushed to the scoreboard
    task automatic predict(input int dir, output bit moved);
        int tx = ex, ty = ey;
        bit oob = 1'b0;
        exp_t e;
        moved = 1'b1;
        case (dir)
            1: if (ex == GRID_W - 1) begin
`ifdef TUNNEL_WRAP_EN
                   tx = 0;
`else
                   oob = 1'b1;
`endif
               end else tx = ex + 1;
            2: if (ex == 0) begin
`ifdef TUNNEL_WRAP_EN
                   tx = GRID_W - 1;
`else
                   oob = 1'b1;
`endif
               end else tx = ex - 1;
            3: if (ey == 0) oob = 1'b1; else ty = ey - 1;
            4: if (ey == GRID_H - 1) oob = 1'b1; else ty = ey + 1;
            default: moved = 1'b0;
        endcase
        if (moved) begin
            mqx = tx; mqy = ty;
            e.step = !oob && !is_wall(tx, ty);
            e.blk  = !e.step;
            e.x    = e.step ? tx : ex;
            e.y    = e.step ? ty : ey;
            sb.push_back(e);
        end
    endtask

    // One full tick: drive dir (optionally glitching it earlier), check query, pulse and position
    task automatic do_tick(input logic [2:0] dir, input bit glitch);
        bit moved;
        exp_t e;
        if (glitch) begin
            int n = 0;
            while (cnt != 3 && n < 3 * STEP_DIV) begin
                @(negedge clk);
                n++;
            end
            ghost_dir = 3'd4;
            @(negedge clk);
        end
        ghost_dir = dir;
        wait_tick();
        predict(int'(dir), moved);
        @(negedge clk);
        chk("q_qx", 32'(wall_qx), mqx);
        chk("q_qy", 32'(wall_qy), mqy);
        chk_quiet("q");
        @(negedge clk);
        chk_quiet("c");
        @(negedge clk);
        if (moved) begin
            e = sb.pop_front();
        end else begin
            e.x = ex; e.y = ey; e.step = 1'b0; e.blk = 1'b0;
        end
        chk("res_step", 32'(step_done), 32'(e.step));
        chk("res_blk", 32'(blocked), 32'(e.blk));
        chk("res_gx", 32'(ghost_x), e.x);
        chk("res_gy", 32'(ghost_y), e.y);
        ex = e.x; ey = e.y;
        @(negedge clk);
        chk_quiet("post");
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // Plain right move into an open cell
        do_tick(3'd1, 1'b0);

        // Upward move into a wall is rejected
        apply_reset();
        wall_en = 1'b1; wall_cx = 9; wall_cy = 6;
        do_tick(3'd3, 1'b0);

        // Stationary and invalid codes
        do_tick(3'd0, 1'b0);
        do_tick(3'd6, 1'b0);
        do_tick(3'd0, 1'b0);
        wall_en = 1'b0;

        // Walk to the left edge, then push against it
        for (int i = 0; i < START_X; i++) do_tick(3'd2, 1'b0);
        do_tick(3'd2, 1'b0);
        do_tick(3'd2, 1'b0);

        // Direction change outside the tick cycle is ignored
        do_tick(3'd1, 1'b1);

        // Top and bottom edges
        for (int i = 0; i < 8; i++) do_tick(3'd3, 1'b0);
        for (int i = 0; i < GRID_H; i++) do_tick(3'd4, 1'b0);

        // Reset while a move is in the QUERY state
        apply_reset();
        ghost_dir = 3'd1;
        wait_tick();
        @(negedge clk);
        chk("rq_qx", 32'(wall_qx), START_X + 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rq_gx", 32'(ghost_x), START_X);
        chk("rq_gy", 32'(ghost_y), START_Y);
        chk("rq_qx2", 32'(wall_qx), START_X);
        chk_quiet("rq");
        reset = 1'b0;
        ex = START_X; ey = START_Y; mqx = START_X; mqy = START_Y;
        @(negedge clk);
        chk_quiet("rq_after");
        chk("rq_gx_hold", 32'(ghost_x), START_X);
        do_tick(3'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
